buzzer_event_decoder: RTL and testbench

// Receive end of the one-hot buzzer pulse interface: watches buzz[2:0], checks that

---
 rtl/buzzer_pkg.sv | 45 ++++
 rtl/buzzer_evt_hold.sv | 66 ++++++
 rtl/buzzer_event_decoder.sv | 158 +++++++++++++++
 tb/tb_buzzer_event_decoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/buzzer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_pkg
// Description : Shared types and constants for the one-hot buzzer pulse
//               interface (zone codes, decoder FSM states, nominal width).
// Revision    : 1.0 - initial release
// ============================================================================
package buzzer_pkg;

  // Nominal buzzer high time in clk cycles, shared with the buzzer generator
  localparam int BUZZ_PULSE_LEN = 31;

  // Zone codes carried on the event port; ZONE_NONE is never emitted
  localparam logic [1:0] ZONE_NONE = 2'd0;
  localparam logic [1:0] ZONE_1    = 2'd1;
  localparam logic [1:0] ZONE_2    = 2'd2;
  localparam logic [1:0] ZONE_3    = 2'd3;

  // Decoder FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    FAULT   = 2'd2
  } state_t;

  // True when exactly one buzzer line is high
  function automatic logic is_onehot(input logic [2:0] line);
    return (line == 3'b001) || (line == 3'b010) || (line == 3'b100);
  endfunction

  // Map a one-hot buzzer line to its zone code
  function automatic logic [1:0] line_to_zone(input logic [2:0] line);
    logic [1:0] zone;
    zone = ZONE_NONE;
    case (line)
      3'b001:  zone = ZONE_1;
      3'b010:  zone = ZONE_2;
      3'b100:  zone = ZONE_3;
      default: zone = ZONE_NONE;
    endcase
    return zone;
  endfunction

endpackage
`default_nettype wire

// File: rtl/buzzer_evt_hold.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_evt_hold
// Description : Single-entry valid/ready holding register for zone events.
//               A new event arriving while the entry is full and not being
//               accepted is dropped and flagged on a sticky overrun bit.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_evt_hold #(
  parameter int WIDTH_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_clr,
  input  logic               i_load,
  input  logic [1:0]         i_zone,
  input  logic [WIDTH_W-1:0] i_width,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [1:0]         o_zone,
  output logic [WIDTH_W-1:0] o_width,
  output logic               o_overrun
);

  logic               r_valid;
  logic [1:0]         r_zone;
  logic [WIDTH_W-1:0] r_width;
  logic               r_overrun;
  logic               w_free;

  // Entry can take a new event if empty or being drained this cycle
  assign w_free = !r_valid || i_ready;

  // Holding register: load when free, otherwise drop valid on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_zone  <= '0;
      r_width <= '0;
    end else if (i_load && w_free) begin
      r_valid <= 1'b1;
      r_zone  <= i_zone;
      r_width <= i_width;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Sticky overrun; a same-cycle clear wins over a new drop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (i_clr) begin
      r_overrun <= 1'b0;
    end else if (i_load && !w_free) begin
      r_overrun <= 1'b1;
    end
  end

  assign o_valid   = r_valid;
  assign o_zone    = r_zone;
  assign o_width   = r_width;
  assign o_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/buzzer_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : buzzer_event_decoder
// Description : Receive side of the one-hot buzzer pulse interface. Measures
//               each pulse, validates one-hotness and width, emits one zone
//               event per good pulse and keeps per-zone saturating counters.
// Revision    : 1.0 - initial release
// ============================================================================
module buzzer_event_decoder
  import buzzer_pkg::*;
#(
  parameter int PULSE_LEN = BUZZ_PULSE_LEN,
  parameter int TOL       = 1,
  parameter int WIDTH_W   = 6,
  parameter int CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [2:0]         buzz,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [1:0]         evt_zone,
  output logic [WIDTH_W-1:0] evt_width,
  output logic               err_width,
  output logic               err_multi,
  output logic               overrun,
  input  logic [1:0]         cnt_sel,
  output logic [CNT_W-1:0]   cnt_out,
  input  logic               clr
);

  localparam logic [WIDTH_W-1:0] c_MIN_W = WIDTH_W'(PULSE_LEN - TOL);
  localparam logic [WIDTH_W-1:0] c_MAX_W = WIDTH_W'(PULSE_LEN + TOL);

  state_t             r_state;
  logic [2:0]         r_line;
  logic [WIDTH_W-1:0] r_width;
  logic               r_err_width;
  logic               r_err_multi;
  logic [CNT_W-1:0]   r_cnt [3];

  logic               w_onehot;
  logic               w_bus_idle;
  logic               w_in_window;
  logic               w_good_end;
  logic [1:0]         w_zone;
  logic [CNT_W-1:0]   w_cnt_out;

  // buzz shares our clock domain, so it is decoded straight off the pins
  assign w_onehot    = is_onehot(buzz);
  assign w_bus_idle  = (buzz == 3'b000);
  assign w_in_window = (r_width >= c_MIN_W) && (r_width <= c_MAX_W);
  assign w_good_end  = ena && (r_state == MEASURE) && w_bus_idle && w_in_window;
  assign w_zone      = line_to_zone(r_line);

  // Pulse FSM with width measurement and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_line      <= 3'b000;
      r_width     <= '0;
      r_err_width <= 1'b0;
      r_err_multi <= 1'b0;
    end else begin
      if (ena) begin
        case (r_state)
          IDLE: begin
            if (w_onehot) begin
              r_state <= MEASURE;
              r_line  <= buzz;
              r_width <= WIDTH_W'(1);
            end else if (!w_bus_idle) begin
              r_state     <= FAULT;
              r_err_multi <= 1'b1;
            end
          end
          MEASURE: begin
            if (buzz == r_line) begin
              if (r_width != '1) begin
                r_width <= r_width + WIDTH_W'(1);
              end
            end else if (w_bus_idle) begin
              r_state <= IDLE;
              if (!w_in_window) begin
                r_err_width <= 1'b1;
              end
            end else begin
              r_state     <= FAULT;
              r_err_multi <= 1'b1;
            end
          end
          FAULT: begin
            if (w_bus_idle) begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
      // Clear overrides any flag set on the same edge; FSM is left alone
      if (clr) begin
        r_err_width <= 1'b0;
        r_err_multi <= 1'b0;
      end
    end
  end

  // One saturating event counter per zone, index 0 holds zone 1
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_zone_cnt
      localparam logic [1:0] c_ZONE = 2'(gi + 1);
      // Count good pulses for this zone; clear beats increment
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt[gi] <= '0;
        end else if (clr) begin
          r_cnt[gi] <= '0;
        end else if (w_good_end && (w_zone == c_ZONE) && (r_cnt[gi] != '1)) begin
          r_cnt[gi] <= r_cnt[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Counter read mux; zone code 0 reads as zero
  always_comb begin
    w_cnt_out = '0;
    case (cnt_sel)
      ZONE_1:  w_cnt_out = r_cnt[0];
      ZONE_2:  w_cnt_out = r_cnt[1];
      ZONE_3:  w_cnt_out = r_cnt[2];
      default: w_cnt_out = '0;
    endcase
  end

  buzzer_evt_hold #(
    .WIDTH_W (WIDTH_W)
  ) u_evt_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (clr),
    .i_load    (w_good_end),
    .i_zone    (w_zone),
    .i_width   (r_width),
    .i_ready   (evt_ready),
    .o_valid   (evt_valid),
    .o_zone    (evt_zone),
    .o_width   (evt_width),
    .o_overrun (overrun)
  );

  assign err_width = r_err_width;
  assign err_multi = r_err_multi;
  assign cnt_out   = w_cnt_out;

endmodule
`default_nettype wire

// File: tb/tb_buzzer_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_buzzer_event_decoder
// Description : Self-checking bench for buzzer_event_decoder: table of single
//               pulses plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buzzer_event_decoder;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [2:0] buzz;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_zone;
  logic [5:0] evt_width;
  logic       err_width;
  logic       err_multi;
  logic       overrun;
  logic [1:0] cnt_sel;
  logic [7:0] cnt_out;
  logic       clr;

  int n_checks;
  int n_errors;

  buzzer_event_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .buzz      (buzz),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_zone  (evt_zone),
    .evt_width (evt_width),
    .err_width (err_width),
    .err_multi (err_multi),
    .overrun   (overrun),
    .cnt_sel   (cnt_sel),
    .cnt_out   (cnt_out),
    .clr       (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] line;
    int         len;
    logic [1:0] sel;
    logic       exp_valid;
    logic [1:0] exp_zone;
    int         exp_width;
    logic       exp_ew;
    logic       exp_em;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are read 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one pulse of len cycles followed by the single end cycle
  task automatic pulse(input logic [2:0] line, input int len);
    buzz = line;
    repeat (len) step();
    buzz = 3'b000;
    step();
  endtask

  // Drain any held event, then clear counters and flags
  task automatic prep();
    buzz      = 3'b000;
    evt_ready = 1'b1;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    ena       = 1'b1;
    buzz      = 3'b000;
    evt_ready = 1'b0;
    cnt_sel   = 2'd1;
    clr       = 1'b0;

    //              line    len sel valid zone width ew    em    cnt
    vecs[0] = '{3'b001, 31, 2'd1, 1'b1, 2'd1, 31, 1'b0, 1'b0, 1};
    vecs[1] = '{3'b010, 29, 2'd2, 1'b0, 2'd0,  0, 1'b1, 1'b0, 0};
    vecs[2] = '{3'b010, 34, 2'd2, 1'b0, 2'd0,  0, 1'b1, 1'b0, 0};
    vecs[3] = '{3'b010, 30, 2'd2, 1'b1, 2'd2, 30, 1'b0, 1'b0, 1};
    vecs[4] = '{3'b010, 32, 2'd2, 1'b1, 2'd2, 32, 1'b0, 1'b0, 1};
    vecs[5] = '{3'b100, 31, 2'd3, 1'b1, 2'd3, 31, 1'b0, 1'b0, 1};
    vecs[6] = '{3'b100, 33, 2'd3, 1'b0, 2'd0,  0, 1'b1, 1'b0, 0};
    vecs[7] = '{3'b100,  1, 2'd3, 1'b0, 2'd0,  0, 1'b1, 1'b0, 0};
    vecs[8] = '{3'b011,  1, 2'd1, 1'b0, 2'd0,  0, 1'b0, 1'b1, 0};
    vecs[9] = '{3'b001, 70, 2'd1, 1'b0, 2'd0,  0, 1'b1, 1'b0, 0};

    // Reset state
    repeat (3) step();
    check("rst_valid", evt_valid, 0);
    check("rst_zone", evt_zone, 0);
    check("rst_width", evt_width, 0);
    check("rst_errw", err_width, 0);
    check("rst_errm", err_multi, 0);
    check("rst_ovr", overrun, 0);
    check("rst_cnt", cnt_out, 0);
    rst_n = 1'b1;
    step();

    // Single-pulse table
    for (int i = 0; i < 10; i++) begin
      prep();
      cnt_sel = vecs[i].sel;
      pulse(vecs[i].line, vecs[i].len);
      check($sformatf("v%0d_valid", i), evt_valid, vecs[i].exp_valid);
      check($sformatf("v%0d_errw", i), err_width, vecs[i].exp_ew);
      check($sformatf("v%0d_errm", i), err_multi, vecs[i].exp_em);
      check($sformatf("v%0d_cnt", i), cnt_out, vecs[i].exp_cnt);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_zone", i), evt_zone, vecs[i].exp_zone);
        check($sformatf("v%0d_width", i), evt_width, vecs[i].exp_width);
      end
    end

    // Active line changes mid-pulse: fault, no event until bus idles
    prep();
    cnt_sel = 2'd1;
    buzz = 3'b001;
    repeat (5) step();
    buzz = 3'b100;
    step();
    check("chg_errm", err_multi, 1);
    buzz = 3'b001;
    step();
    buzz = 3'b000;
    step();
    check("chg_valid", evt_valid, 0);
    check("chg_cnt", cnt_out, 0);
    cnt_sel = 2'd2;
    pulse(3'b010, 31);
    check("chg_recover_valid", evt_valid, 1);
    check("chg_recover_zone", evt_zone, 2);

    // Back-to-back zone-3 pulses with no ready: hold, overrun, drain
    prep();
    evt_ready = 1'b0;
    cnt_sel   = 2'd3;
    pulse(3'b100, 31);
    check("ovr_first_valid", evt_valid, 1);
    check("ovr_first_width", evt_width, 31);
    check("ovr_first_flag", overrun, 0);
    pulse(3'b100, 30);
    check("ovr_hold_valid", evt_valid, 1);
    check("ovr_hold_zone", evt_zone, 3);
    check("ovr_hold_width", evt_width, 31);
    check("ovr_flag", overrun, 1);
    check("ovr_cnt", cnt_out, 2);
    evt_ready = 1'b1;
    step();
    check("ovr_drain", evt_valid, 0);

    // Counter saturation, then clear of counters and all sticky flags
    cnt_sel = 2'd1;
    for (int i = 0; i < 256; i++) pulse(3'b001, 31);
    check("sat_cnt", cnt_out, 255);
    pulse(3'b001, 5);
    pulse(3'b011, 1);
    check("pre_clr_errw", err_width, 1);
    check("pre_clr_errm", err_multi, 1);
    check("pre_clr_ovr", overrun, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_cnt1", cnt_out, 0);
    check("clr_errw", err_width, 0);
    check("clr_errm", err_multi, 0);
    check("clr_ovr", overrun, 0);
    cnt_sel = 2'd3;
    check("clr_cnt3", cnt_out, 0);

    // Async reset in the middle of a pulse, remainder rejected on width
    prep();
    evt_ready = 1'b0;
    cnt_sel   = 2'd1;
    pulse(3'b001, 31);
    check("prerst_valid", evt_valid, 1);
    buzz = 3'b001;
    repeat (10) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", evt_valid, 0);
    check("arst_zone", evt_zone, 0);
    check("arst_width", evt_width, 0);
    check("arst_cnt", cnt_out, 0);
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (15) step();
    buzz = 3'b000;
    step();
    check("arst_rem_valid", evt_valid, 0);
    check("arst_rem_errw", err_width, 1);

    // ena low for 10 cycles inside a 31-cycle pulse: measures 21
    prep();
    cnt_sel = 2'd1;
    buzz = 3'b001;
    repeat (10) step();
    ena = 1'b0;
    repeat (10) step();
    ena = 1'b1;
    repeat (11) step();
    buzz = 3'b000;
    step();
    check("ena_valid", evt_valid, 0);
    check("ena_errw", err_width, 1);
    check("ena_cnt", cnt_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
